bus_copy_dma: RTL and testbench

Bus-initiator copy engine: moves a block of 32-bit words from a source address range to a destination range over the shared single-beat request bus. It is the initiator that drives the read-only IMEM slave adapter and the DMEM slave; it copies `.rodata` from IMEM to DMEM in hardware instead of with a boot-code loop. A control register block or the boot sequencer drives it through a start/done interface.

---
 rtl/bus_copy_dma.sv | 87 ++++++++
 tb/tb_bus_copy_dma.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_copy_dma.sv
// bus_copy_dma: single-beat bus initiator copying len_words 32-bit words from src to dst.
// Optional read-data checksum is built only when RV_DMA_CHECKSUM_EN is defined.
module bus_copy_dma #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len_words,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          checksum,
    output logic                 req_valid,
    output logic [31:0]          req_addr,
    output logic                 req_we,
    output logic [31:0]          req_wdata,
    input  logic                 req_ready,
    input  logic [31:0]          req_rdata
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t               state_q, state_d;
    logic [31:0]          src_q, src_d, dst_q, dst_d, buf_q, buf_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            buf_q   <= buf_d;
            rem_q   <= rem_d;
        end
    end
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        buf_d   = buf_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = (len_words == '0) ? DONE : RD;
                src_d   = {src_addr[31:2], 2'b00};
                dst_d   = {dst_addr[31:2], 2'b00};
                rem_d   = len_words;
            end
            RD: if (req_ready) begin
                buf_d   = req_rdata;
                state_d = WR;
            end
            WR: if (req_ready) begin
                src_d   = src_q + 32'd4;
                dst_d   = dst_q + 32'd4;
                rem_d   = rem_q - LEN_WIDTH'(1);
                state_d = (rem_q == LEN_WIDTH'(1)) ? DONE : RD;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Bus outputs decode only registered state, so req_ready never reaches req_valid.
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign req_valid = (state_q == RD) || (state_q == WR);
    assign req_we    = state_q == WR;
    assign req_addr  = (state_q == RD) ? src_q : (state_q == WR) ? dst_q : '0;
    assign req_wdata = req_we ? buf_q : '0;
`ifdef RV_DMA_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
    assign csum_d = (state_q == IDLE && start) ? '0 :
                    (state_q == RD && req_ready) ? csum_q + req_rdata : csum_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) csum_q <= '0;
        else          csum_q <= csum_d;
    end
    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_bus_copy_dma.sv
// tb_bus_copy_dma: table-driven and randomized copies against a word-level memory model.
module tb_bus_copy_dma;
    logic        clk = 0, reset_n = 0, start = 0;
    logic [31:0] src_addr = 0, dst_addr = 0;
    logic [15:0] len_words = 0;
    logic        busy, done, req_valid, req_we;
    logic        req_ready = 1;
    logic [31:0] checksum, req_addr, req_wdata;
    logic [31:0] req_rdata = 0;

    bus_copy_dma #(.LEN_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len_words(len_words), .busy(busy), .done(done),
        .checksum(checksum), .req_valid(req_valid), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata), .req_ready(req_ready),
        .req_rdata(req_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } xfer_t;
    typedef struct {
        logic [31:0] src; logic [31:0] dst; int len; int mode; bit mid; bit fixed; int exp_done;
    } vec_t;

    xfer_t       log_q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_chk = 0, n_fail = 0;
    int          mode = 0, waits = 0, wr_count = 0, stall_left = 0;
    bit          stalled = 0, prev_stall = 0;
    logic        p_we, rdy;
    logic [31:0] p_addr, p_wdata;

    function automatic logic [31:0] rd(logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave: mode 0 zero-wait, 1 random waits, 2 three-cycle stall on the second write.
    always @(negedge clk) begin
        check("bus_idle_zero",
              32'((!req_we && req_wdata != 0) || (!req_valid && (req_we || req_addr != 0))), 0);
        if (prev_stall) begin
            check("stall_valid_held", 32'(req_valid), 1);
            check("stall_addr_stable", req_addr, p_addr);
            check("stall_we_stable", 32'(req_we), 32'(p_we));
            check("stall_wdata_stable", req_wdata, p_wdata);
        end
        rdy = 1;
        if (req_valid) begin
            if (mode == 2 && req_we && wr_count == 1 && !stalled) begin
                stall_left = 3;
                stalled = 1;
            end
            if (stall_left > 0) begin
                rdy = 0;
                stall_left--;
            end else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
        end
        req_ready = rdy;
        req_rdata = (req_valid && !req_we) ? rd(req_addr) : $urandom;
        if (req_valid && rdy) begin
            log_q.push_back('{req_we, req_addr, req_we ? req_wdata : req_rdata});
            if (req_we) begin
                mem[req_addr] = req_wdata;
                wr_count++;
            end
        end
        if (req_valid && !rdy) waits++;
        prev_stall = req_valid && !rdy;
        p_addr = req_addr;
        p_we = req_we;
        p_wdata = req_wdata;
    end

    task automatic run_copy(vec_t v);
        xfer_t       exp_q[$];
        logic [31:0] refm [logic [31:0]];
        logic [31:0] s, d, w, sum, d0;
        int          cyc, done_cyc, busy_bad;
        s = v.src & ~32'h3;
        d = v.dst & ~32'h3;
        d0 = d;
        for (int k = 0; k < v.len; k++) mem[s + 32'(4 * k)] = v.fixed ? 32'(k + 1) : $urandom;
        refm = mem;
        sum = 0;
        for (int k = 0; k < v.len; k++) begin
            w = refm.exists(s) ? refm[s] : 32'h0;
            exp_q.push_back('{1'b0, s, w});
            exp_q.push_back('{1'b1, d, w});
            refm[d] = w;
            sum += w;
            s += 4;
            d += 4;
        end
        log_q.delete();
        waits = 0;
        wr_count = 0;
        stalled = 0;
        mode = v.mode;
        src_addr = v.src;
        dst_addr = v.dst;
        len_words = 16'(v.len);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        cyc = 0;
        done_cyc = 0;
        busy_bad = 0;
        while (done_cyc == 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (!busy) busy_bad++;
            if (done) done_cyc = cyc;
            if (v.mid && cyc == 3) begin
                src_addr = 32'h12340;
                dst_addr = 32'h55550;
                len_words = 16'd7;
                start = 1;
            end
            if (v.mid && cyc == 4) start = 0;
        end
        if (done_cyc == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", cyc);
        end
        check("done_cycle", 32'(done_cyc), 32'(v.exp_done + (v.mode == 1 ? waits : 0)));
        check("busy_span", 32'(busy_bad), 0);
        check("xfer_count", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check("xfer_we", 32'(log_q[i].we), 32'(exp_q[i].we));
            check("xfer_addr", log_q[i].addr, exp_q[i].addr);
            check("xfer_data", log_q[i].data, exp_q[i].data);
        end
        for (int k = 0; k < v.len; k++)
            check("dst_mem", rd(d0 + 32'(4 * k)), refm[d0 + 32'(4 * k)]);
`ifdef RV_DMA_CHECKSUM_EN
        check("checksum", checksum, sum);
`else
        check("checksum", checksum, 0);
`endif
        @(negedge clk);
        check("idle_after_done", {30'h0, busy, done}, 0);
        mode = 0;
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_valid"}, 32'(req_valid), 0);
        check({tag, "_addr"}, req_addr, 0);
        check({tag, "_we"}, 32'(req_we), 0);
        check({tag, "_wdata"}, req_wdata, 0);
        check({tag, "_checksum"}, checksum, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        vec_t rv;
        int   idle_bad;
        vt[0] = '{32'h00000100, 32'h00010000, 4, 0, 0, 1, 9};
        vt[1] = '{32'h00000100, 32'h00010000, 4, 2, 0, 0, 12};
        vt[2] = '{32'h00000200, 32'h00000300, 0, 0, 0, 0, 1};
        vt[3] = '{32'hFFFFFFF8, 32'h00004000, 3, 0, 0, 0, 7};
        vt[4] = '{32'h00000500, 32'h00000600, 5, 0, 1, 0, 11};
        vt[5] = '{32'h00000703, 32'h00000802, 6, 1, 0, 0, 13};
        vt[6] = '{32'h00000900, 32'h00000904, 4, 0, 0, 1, 9};
        vt[7] = '{32'h00002000, 32'h00003000, 20, 1, 0, 0, 41};
        reset_n = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            run_copy(vt[i]);
`ifdef RV_DMA_CHECKSUM_EN
            if (i == 0) check("checksum_4w", checksum, 32'd10);
`else
            if (i == 0) check("checksum_4w", checksum, 32'd0);
`endif
        end
        for (int r = 0; r < 6; r++) begin
            rv.src = $urandom;
            rv.dst = $urandom;
            rv.len = $urandom_range(1, 12);
            rv.mode = 1;
            rv.mid = 0;
            rv.fixed = 0;
            rv.exp_done = 2 * rv.len + 1;
            run_copy(rv);
        end
        src_addr = 32'h100;
        dst_addr = 32'h20000;
        len_words = 16'd5;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (4) @(negedge clk);
        check("rst_in_write", {30'h0, req_valid, req_we}, 32'h3);
        #2 reset_n = 0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        reset_n = 1;
        idle_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (req_valid || busy) idle_bad++;
        end
        check("post_reset_quiet", 32'(idle_bad), 0);
        run_copy(vt[0]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
